cpu6_ifid_buffer: RTL

Fetch-to-decode stage of the cpu6 pipeline. It accepts fetched instructions through a valid/ready handshake into a small FIFO and drives the IF/ID register that feeds decode, and through decode the ID/EX pipeline register. It honours hazard stalls and flushes. Before a serializing instruction (SYSTEM/CSR or FENCE) it inserts a fixed number of bubbles, then tags that instruction with empty_pipeline_reqD.

---
 rtl/cpu6_ifid_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cpu6_ifid_buffer.sv
// cpu6 fetch-to-decode buffer: a small instruction FIFO feeding the IF/ID
// register. A serializing instruction (SYSTEM/CSR or FENCE) is held at the
// FIFO head until DRAIN_CYCLES bubbles have gone down the pipe. It then
// issues tagged with empty_pipeline_reqD.
module cpu6_ifid_buffer #(
  parameter int unsigned        XLEN         = 32,
  parameter int unsigned        DEPTH        = 2,
  parameter int unsigned        DRAIN_CYCLES = 3,
  parameter logic [XLEN-1:0]    NOP_INSTR    = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flash,
  input  logic            stall,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] instrD,
  output logic            validD,
  output logic            empty_pipeline_reqD
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic [PW:0]     count;
  logic [PW-1:0]   rd_ptr, wr_ptr;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [XLEN-1:0] head_pc, head_instr;
  logic            head_serial;
  logic            fifo_empty;
  logic            push, pop;
  logic            load_bubble, load_head, load_tag;

  assign instr_ready = (count < FULL_COUNT);
  assign push        = instr_valid & instr_ready & ~flash;
  assign fifo_empty  = (count == '0);
  assign head_pc     = pc_mem[rd_ptr];
  assign head_instr  = instr_mem[rd_ptr];
  assign head_serial = (head_instr[6:0] == 7'b1110011) ||
                       (head_instr[6:0] == 7'b0001111);

  // FIFO storage; contents are only meaningful once written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc;
      instr_mem[wr_ptr] <= instr;
    end
  end

  // FIFO occupancy and pointers; flash empties the queue and drops any push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flash) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state: a serializing head starts a drain; stall freezes everything
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (flash) begin
      state_nxt = IDLE;
      drain_nxt = '0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (!fifo_empty && head_serial) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) drain_nxt = drain_cnt - 1'b1;
          else                 state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          drain_nxt = '0;
        end
      endcase
    end
  end

  // Output decode: chooses bubble vs. head for the IF/ID register and pops
  // the head. The IDLE->DRAIN bubble counts as the first drain bubble.
  always_comb begin
    pop         = 1'b0;
    load_bubble = 1'b0;
    load_head   = 1'b0;
    load_tag    = 1'b0;
    if (flash) begin
      load_bubble = 1'b1;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (fifo_empty || head_serial) begin
            load_bubble = 1'b1;
          end else begin
            load_head = 1'b1;
            pop       = 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) begin
            load_bubble = 1'b1;
          end else begin
            load_head = 1'b1;
            load_tag  = 1'b1;
            pop       = 1'b1;
          end
        end
        default: load_bubble = 1'b1;
      endcase
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcD                 <= '0;
      instrD              <= NOP_INSTR;
      validD              <= 1'b0;
      empty_pipeline_reqD <= 1'b0;
    end else if (load_bubble) begin
      pcD                 <= '0;
      instrD              <= NOP_INSTR;
      validD              <= 1'b0;
      empty_pipeline_reqD <= 1'b0;
    end else if (load_head) begin
      pcD                 <= head_pc;
      instrD              <= head_instr;
      validD              <= 1'b1;
      empty_pipeline_reqD <= load_tag;
    end
  end

endmodule
